// File: rtl/show_sel_scan_pkg.sv
// Shared definitions for the scanned multi-source 7-segment display:
// FSM encodings, display codes, mode indices and a width helper.
package show_sel_scan_pkg;

    typedef enum logic {
        ST_SHOW   = 1'b0,
        ST_BANNER = 1'b1
    } state_e;

    localparam logic [3:0] BLANK_CODE = 4'd15;
    localparam logic [3:0] LABEL_L    = 4'd12;
    localparam logic [3:0] LABEL_V    = 4'd10;

    localparam int unsigned MODE_CLOCK = 0;
    localparam int unsigned MODE_DATE  = 1;
    localparam int unsigned MODE_ALARM = 2;

    // Mode select width: never narrower than one bit.
    function automatic int unsigned mode_width(input int unsigned num_src);
        return (num_src > 1) ? $clog2(num_src) : 1;
    endfunction

endpackage

// File: rtl/show_sel_scan_tick_gen.sv
// Free-running prescaler: counts 0..DIV-1 and pulses tick_o for the one
// cycle in which the count has just wrapped back to 0.
module tick_gen #(
    parameter int unsigned DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          tick_q;
    logic          tick_d;

    always_comb begin
        cnt_d  = cnt_q + CW'(1);
        tick_d = 1'b0;
        if (cnt_q == LAST) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/show_sel_scan.sv
// Multiplexed 7-segment driver: selects one of NUM_SRC frames, shows a
// per-mode banner after each mode change, blinks masked digits, scans digits.
module show_sel_scan
    import show_sel_scan_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned NUM_SRC      = 3,
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BANNER_TICKS = 4000,
    parameter int unsigned BLINK_DIV    = 250
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [mode_width(NUM_SRC)-1:0]    mode,
    input  logic [NUM_SRC*NUM_DIGITS*4-1:0]   src_bcd,
    input  logic [NUM_SRC*NUM_DIGITS*4-1:0]   banner_bcd,
    input  logic [NUM_DIGITS-1:0]             blink_mask,
    output logic [NUM_DIGITS*4-1:0]           disp_bcd,
    output logic [NUM_DIGITS-1:0]             digit_en,
    output logic [3:0]                        digit_bcd,
    output logic                              banner_active
);

    localparam int unsigned MW = mode_width(NUM_SRC);
    localparam int unsigned FW = NUM_DIGITS * 4;
    localparam int unsigned SW = $clog2(NUM_DIGITS);
    localparam int unsigned BW = $clog2(BANNER_TICKS + 1);
    localparam int unsigned KW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic          scan_tick;

    state_e        state_q;
    state_e        state_d;
    logic [MW-1:0] mode_q;
    logic [MW-1:0] mode_d;
    logic [BW-1:0] bcnt_q;
    logic [BW-1:0] bcnt_d;
    logic          blink_q;
    logic          blink_d;
    logic [KW-1:0] bdiv_q;
    logic [KW-1:0] bdiv_d;
    logic [SW-1:0] scan_q;
    logic [SW-1:0] scan_d;
    logic [NUM_DIGITS-1:0] digit_en_q;
    logic [NUM_DIGITS-1:0] digit_en_d;
    logic [3:0]    digit_bcd_q;
    logic [3:0]    digit_bcd_d;
    logic [FW-1:0] disp_q;
    logic [FW-1:0] disp_d;

    logic          mode_valid;
    logic          mode_chg;
    logic [FW-1:0] src_sel;
    logic [FW-1:0] ban_sel;

    tick_gen #(
        .DIV (SCAN_DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .tick_o (scan_tick)
    );

    assign mode_valid = (32'(mode) < NUM_SRC);
    assign mode_chg   = mode_valid && (mode != mode_q);

    // Frame selection by source index; out-of-range modes see an all-blank frame.
    always_comb begin
        src_sel = {NUM_DIGITS{BLANK_CODE}};
        ban_sel = {NUM_DIGITS{BLANK_CODE}};
        for (int unsigned s = 0; s < NUM_SRC; s++) begin
            if (32'(mode) == s) begin
                src_sel = src_bcd[s*FW +: FW];
                ban_sel = banner_bcd[s*FW +: FW];
            end
        end
    end

    // Banner FSM: a fresh valid mode always reloads the hold count.
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        mode_d  = mode;
        if (!mode_valid) begin
            state_d = ST_SHOW;
            bcnt_d  = '0;
        end else if (mode_chg) begin
            state_d = ST_BANNER;
            bcnt_d  = BW'(BANNER_TICKS);
        end else if ((state_q == ST_BANNER) && scan_tick) begin
            bcnt_d = bcnt_q - BW'(1);
            if (bcnt_q == BW'(1)) begin
                state_d = ST_SHOW;
            end
        end
    end

    // Blink phase runs in every state so it stays continuous across banners.
    always_comb begin
        blink_d = blink_q;
        bdiv_d  = bdiv_q;
        if (scan_tick) begin
            if (bdiv_q == KW'(BLINK_DIV - 1)) begin
                bdiv_d  = '0;
                blink_d = ~blink_q;
            end else begin
                bdiv_d = bdiv_q + KW'(1);
            end
        end
    end

    always_comb begin
        disp_d = src_sel;
        if (!mode_valid) begin
            disp_d = {NUM_DIGITS{BLANK_CODE}};
        end else if (state_d == ST_BANNER) begin
            disp_d = ban_sel;
        end else if (blink_q) begin
            for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
                if (blink_mask[d]) begin
                    disp_d[d*4 +: 4] = BLANK_CODE;
                end
            end
        end
    end

    // Digit scan: the enabled digit shows the frame as registered at the tick.
    always_comb begin
        scan_d      = scan_q;
        digit_en_d  = digit_en_q;
        digit_bcd_d = digit_bcd_q;
        if (scan_tick) begin
            scan_d     = (scan_q == SW'(NUM_DIGITS - 1)) ? '0 : scan_q + SW'(1);
            digit_en_d = '0;
            for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
                if (scan_d == SW'(d)) begin
                    digit_en_d[d] = 1'b1;
                    digit_bcd_d   = disp_q[d*4 +: 4];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_SHOW;
            mode_q      <= '0;
            bcnt_q      <= '0;
            blink_q     <= 1'b0;
            bdiv_q      <= '0;
            scan_q      <= '0;
            digit_en_q  <= NUM_DIGITS'(1);
            digit_bcd_q <= BLANK_CODE;
            disp_q      <= {NUM_DIGITS{BLANK_CODE}};
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            bcnt_q      <= bcnt_d;
            blink_q     <= blink_d;
            bdiv_q      <= bdiv_d;
            scan_q      <= scan_d;
            digit_en_q  <= digit_en_d;
            digit_bcd_q <= digit_bcd_d;
            disp_q      <= disp_d;
        end
    end

    assign disp_bcd      = disp_q;
    assign digit_en      = digit_en_q;
    assign digit_bcd     = digit_bcd_q;
    assign banner_active = (state_q == ST_BANNER);

endmodule

// File: tb/tb_show_sel_scan.sv
// Self-checking bench for show_sel_scan: a cycle model pushes expected
// outputs per clock, scenario tasks pop them and add targeted checks.
module tb_show_sel_scan;

    localparam int ND        = 4;
    localparam int NS        = 3;
    localparam int SCAN_DIV  = 4;
    localparam int BT        = 2;
    localparam int BD        = 2;

    localparam logic [15:0] SRC0 = 16'h1234;
    localparam logic [15:0] SRC1 = 16'h0427;
    localparam logic [15:0] SRC2 = 16'h9876;
    localparam logic [15:0] BAN0 = 16'hC1A0;
    localparam logic [15:0] BAN1 = 16'h5A5A;
    localparam logic [15:0] BAN2 = 16'hCAF0;

    typedef struct packed {
        logic [15:0] disp;
        logic [3:0]  den;
        logic [3:0]  dbcd;
        logic        ba;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [1:0]  mode;
    logic [47:0] src_bcd;
    logic [47:0] banner_bcd;
    logic [3:0]  blink_mask;
    logic [15:0] disp_bcd;
    logic [3:0]  digit_en;
    logic [3:0]  digit_bcd;
    logic        banner_active;

    int tests_run    = 0;
    int tests_failed = 0;

    exp_t sb_q[$];

    bit          m_tick, m_banner, m_blink;
    int          m_pre, m_scan, m_bcnt, m_bdiv, m_mode_q;
    logic [3:0]  m_den, m_dbcd;
    logic [15:0] m_disp;

    show_sel_scan #(
        .NUM_DIGITS   (ND),
        .NUM_SRC      (NS),
        .SCAN_DIV     (SCAN_DIV),
        .BANNER_TICKS (BT),
        .BLINK_DIV    (BD)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mode          (mode),
        .src_bcd       (src_bcd),
        .banner_bcd    (banner_bcd),
        .blink_mask    (blink_mask),
        .disp_bcd      (disp_bcd),
        .digit_en      (digit_en),
        .digit_bcd     (digit_bcd),
        .banner_active (banner_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance the reference one clock from the current inputs, queue the result, then clock the DUT.
    task automatic cycle();
        exp_t        e;
        bit          n_tick, n_banner, n_blink, valid;
        int          n_pre, n_scan, n_bcnt, n_bdiv, mi;
        logic [15:0] n_disp;
        logic [3:0]  n_den, n_dbcd;
        if (rst) begin
            n_tick = 0; n_pre = 0; n_scan = 0; n_den = 4'b0001; n_dbcd = 4'hF;
            n_disp = 16'hFFFF; n_banner = 0; n_bcnt = 0; n_blink = 0; n_bdiv = 0; mi = 0;
        end else begin
            mi     = int'(mode);
            valid  = (mi < NS);
            n_tick = (m_pre == SCAN_DIV - 1);
            n_pre  = n_tick ? 0 : m_pre + 1;
            n_banner = m_banner;
            n_bcnt   = m_bcnt;
            if (!valid) begin
                n_banner = 0; n_bcnt = 0;
            end else if (mi != m_mode_q) begin
                n_banner = 1; n_bcnt = BT;
            end else if (m_banner && m_tick) begin
                n_bcnt = m_bcnt - 1;
                if (n_bcnt == 0) n_banner = 0;
            end
            for (int d = 0; d < ND; d++) begin
                if (!valid)                        n_disp[d*4 +: 4] = 4'hF;
                else if (n_banner)                 n_disp[d*4 +: 4] = banner_bcd[(mi*ND + d)*4 +: 4];
                else if (m_blink && blink_mask[d]) n_disp[d*4 +: 4] = 4'hF;
                else                               n_disp[d*4 +: 4] = src_bcd[(mi*ND + d)*4 +: 4];
            end
            n_blink = m_blink;
            n_bdiv  = m_bdiv;
            if (m_tick) begin
                if (m_bdiv == BD - 1) begin n_bdiv = 0; n_blink = !m_blink; end
                else n_bdiv = m_bdiv + 1;
            end
            n_scan = m_scan; n_den = m_den; n_dbcd = m_dbcd;
            if (m_tick) begin
                n_scan = (m_scan + 1) % ND;
                n_den  = 4'b0001 << n_scan;
                n_dbcd = m_disp[n_scan*4 +: 4];
            end
        end
        m_tick = n_tick; m_pre = n_pre; m_scan = n_scan; m_den = n_den; m_dbcd = n_dbcd;
        m_disp = n_disp; m_banner = n_banner; m_bcnt = n_bcnt; m_blink = n_blink;
        m_bdiv = n_bdiv; m_mode_q = mi;
        e.disp = n_disp; e.den = n_den; e.dbcd = n_dbcd; e.ba = n_banner;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Clock until the banner is over, checking every cycle against the scoreboard.
    task automatic settle();
        exp_t e, obs;
        bit   done = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            cycle(); e = sb_q.pop_front(); obs = {disp_bcd, digit_en, digit_bcd, banner_active};
            tests_run++;
            if (obs !== e) begin tests_failed++; $display("FAIL settle_sb t=%0t got %h want %h", $time, obs, e); end
            if (!banner_active) done = 1;
        end
        tests_run++;
        if (!done) begin tests_failed++; $display("FAIL settle_timeout: banner_active=%b want 0", banner_active); end
    endtask

    task automatic test_reset();
        exp_t e, obs;
        rst = 1'b1;
        repeat (3) begin
            cycle(); e = sb_q.pop_front(); obs = {disp_bcd, digit_en, digit_bcd, banner_active};
            tests_run++;
            if (obs !== e) begin tests_failed++; $display("FAIL reset_sb t=%0t got %h want %h", $time, obs, e); end
        end
        tests_run++;
        if (disp_bcd !== 16'hFFFF || digit_en !== 4'b0001 || digit_bcd !== 4'hF || banner_active !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_values: disp=%h en=%b bcd=%h ba=%b want FFFF 0001 F 0",
                     disp_bcd, digit_en, digit_bcd, banner_active);
        end
    endtask

    task automatic test_scan();
        exp_t       e, obs;
        logic [3:0] exp_en [5]  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        logic [3:0] exp_bcd [5] = '{4'h3, 4'h2, 4'h1, 4'h4, 4'h3};
        logic [3:0] prev_en;
        int         n = 0;
        int         last = 0;
        rst = 1'b0; mode = 2'd0; blink_mask = 4'b0000;
        cycle(); e = sb_q.pop_front(); obs = {disp_bcd, digit_en, digit_bcd, banner_active};
        tests_run++;
        if (obs !== e) begin tests_failed++; $display("FAIL scan_sb t=%0t got %h want %h", $time, obs, e); end
        tests_run++;
        if (disp_bcd !== SRC0 || banner_active !== 1'b0) begin
            tests_failed++; $display("FAIL scan_first_frame: disp=%h ba=%b want %h 0", disp_bcd, banner_active, SRC0);
        end
        prev_en = digit_en;
        for (int c = 1; c <= 40 && n < 5; c++) begin
            cycle(); e = sb_q.pop_front(); obs = {disp_bcd, digit_en, digit_bcd, banner_active};
            tests_run++;
            if (obs !== e) begin tests_failed++; $display("FAIL scan_sb t=%0t got %h want %h", $time, obs, e); end
            if (digit_en !== prev_en) begin
                tests_run++;
                if (digit_en !== exp_en[n] || digit_bcd !== exp_bcd[n]) begin
                    tests_failed++;
                    $display("FAIL scan_seq[%0d]: en=%b bcd=%h want en=%b bcd=%h", n, digit_en, digit_bcd, exp_en[n], exp_bcd[n]);
                end
                if (n > 0) begin
                    tests_run++;
                    if (c - last != SCAN_DIV) begin
                        tests_failed++; $display("FAIL scan_period: %0d cycles want %0d", c - last, SCAN_DIV);
                    end
                end
                last = c;
                n++;
            end
            prev_en = digit_en;
        end
        tests_run++;
        if (n != 5) begin tests_failed++; $display("FAIL scan_timeout: %0d digit steps want 5", n); end
    endtask

    task automatic test_banner();
        exp_t e, obs;
        logic [3:0] prev_en;
        logic prev_ba;
        int   active = 0;
        int   ticks = 0;
        bit   seen = 0;
        bit   done = 0;
        mode = 2'd2;
        prev_en = digit_en; prev_ba = banner_active;
        for (int c = 0; c < 40 && !done; c++) begin
            cycle(); e = sb_q.pop_front(); obs = {disp_bcd, digit_en, digit_bcd, banner_active};
            tests_run++;
            if (obs !== e) begin tests_failed++; $display("FAIL banner_sb t=%0t got %h want %h", $time, obs, e); end
            if (digit_en !== prev_en && prev_ba) ticks++;
            if (banner_active) begin
                seen = 1; active++;
                tests_run++;
                if (disp_bcd !== BAN2) begin tests_failed++; $display("FAIL banner_label: disp=%h want %h", disp_bcd, BAN2); end
            end else if (seen) begin
                done = 1;
                tests_run++;
                if (disp_bcd !== SRC2) begin tests_failed++; $display("FAIL banner_return: disp=%h want %h", disp_bcd, SRC2); end
            end
            prev_en = digit_en; prev_ba = banner_active;
        end
        tests_run++;
        if (!done) begin tests_failed++; $display("FAIL banner_timeout: seen=%0d ended=0 want ended=1", seen); end
        tests_run++;
        if (ticks != BT) begin tests_failed++; $display("FAIL banner_ticks: %0d want %0d", ticks, BT); end
        tests_run++;
        if (active < (BT - 1)*SCAN_DIV + 1 || active > BT*SCAN_DIV) begin
            tests_failed++; $display("FAIL banner_cycles: %0d want %0d..%0d", active, (BT - 1)*SCAN_DIV + 1, BT*SCAN_DIV);
        end
    endtask

    task automatic test_restart();
        exp_t e, obs;
        logic [3:0] prev_en;
        int   ticks = 0;
        bit   switched = 0;
        bit   done = 0;
        mode = 2'd0;
        settle();
        mode = 2'd1;
        cycle(); e = sb_q.pop_front(); obs = {disp_bcd, digit_en, digit_bcd, banner_active};
        tests_run++;
        if (obs !== e) begin tests_failed++; $display("FAIL restart_sb t=%0t got %h want %h", $time, obs, e); end
        tests_run++;
        if (banner_active !== 1'b1 || disp_bcd !== BAN1) begin
            tests_failed++; $display("FAIL restart_enter: ba=%b disp=%h want 1 %h", banner_active, disp_bcd, BAN1);
        end
        prev_en = digit_en;
        for (int c = 0; c < 60 && !done; c++) begin
            if (ticks == 1 && !switched) begin mode = 2'd2; switched = 1; end
            cycle(); e = sb_q.pop_front(); obs = {disp_bcd, digit_en, digit_bcd, banner_active};
            tests_run++;
            if (obs !== e) begin tests_failed++; $display("FAIL restart_sb t=%0t got %h want %h", $time, obs, e); end
            if (digit_en !== prev_en) ticks++;
            if (!banner_active) done = 1;
            else if (switched) begin
                tests_run++;
                if (disp_bcd !== BAN2) begin tests_failed++; $display("FAIL restart_label: disp=%h want %h", disp_bcd, BAN2); end
            end
            prev_en = digit_en;
        end
        tests_run++;
        if (!done) begin tests_failed++; $display("FAIL restart_timeout: banner still active, want ended"); end
        tests_run++;
        if (ticks != BT + 1) begin tests_failed++; $display("FAIL restart_ticks: %0d want %0d", ticks, BT + 1); end
    endtask

    task automatic test_load_wins();
        exp_t e, obs;
        logic [3:0] prev_en;
        int   active = 1;
        int   ticks = 0;
        bit   found = 0;
        bit   done = 0;
        for (int c = 0; c < 10 && !found; c++) begin
            if (m_tick) found = 1;
            else begin
                cycle(); e = sb_q.pop_front(); obs = {disp_bcd, digit_en, digit_bcd, banner_active};
                tests_run++;
                if (obs !== e) begin tests_failed++; $display("FAIL loadwins_sb t=%0t got %h want %h", $time, obs, e); end
            end
        end
        tests_run++;
        if (!found) begin tests_failed++; $display("FAIL loadwins_align: no scan tick found, want one within 10 cycles"); end
        mode = 2'd1;
        prev_en = digit_en;
        cycle(); e = sb_q.pop_front(); obs = {disp_bcd, digit_en, digit_bcd, banner_active};
        tests_run++;
        if (obs !== e) begin tests_failed++; $display("FAIL loadwins_sb t=%0t got %h want %h", $time, obs, e); end
        tests_run++;
        if (banner_active !== 1'b1 || digit_en === prev_en) begin
            tests_failed++; $display("FAIL loadwins_coincide: ba=%b en=%b prev_en=%b want ba=1 and a digit step", banner_active, digit_en, prev_en);
        end
        prev_en = digit_en;
        for (int c = 0; c < 40 && !done; c++) begin
            cycle(); e = sb_q.pop_front(); obs = {disp_bcd, digit_en, digit_bcd, banner_active};
            tests_run++;
            if (obs !== e) begin tests_failed++; $display("FAIL loadwins_sb t=%0t got %h want %h", $time, obs, e); end
            if (digit_en !== prev_en) ticks++;
            if (banner_active) active++;
            else done = 1;
            prev_en = digit_en;
        end
        tests_run++;
        if (!done || ticks != BT) begin tests_failed++; $display("FAIL loadwins_ticks: %0d ended=%0d want %0d ended=1", ticks, done, BT); end
        tests_run++;
        if (active != BT*SCAN_DIV) begin tests_failed++; $display("FAIL loadwins_cycles: %0d want %0d", active, BT*SCAN_DIV); end
    endtask

    task automatic test_blink();
        exp_t e, obs;
        logic [3:0] prev_nib;
        int   nchg = 0;
        int   last = 0;
        bit   seen = 0;
        bit   done = 0;
        mode = 2'd0; blink_mask = 4'b0000;
        settle();
        blink_mask = 4'b0001;
        prev_nib = disp_bcd[3:0];
        for (int c = 1; c <= 48; c++) begin
            cycle(); e = sb_q.pop_front(); obs = {disp_bcd, digit_en, digit_bcd, banner_active};
            tests_run++;
            if (obs !== e) begin tests_failed++; $display("FAIL blink_sb t=%0t got %h want %h", $time, obs, e); end
            tests_run++;
            if (disp_bcd[15:4] !== 12'h123 || (disp_bcd[3:0] !== 4'h4 && disp_bcd[3:0] !== 4'hF)) begin
                tests_failed++; $display("FAIL blink_digits: disp=%h want 123 with digit0 4 or F", disp_bcd);
            end
            if (disp_bcd[3:0] !== prev_nib) begin
                if (nchg >= 2) begin
                    tests_run++;
                    if (c - last != BD*SCAN_DIV) begin
                        tests_failed++; $display("FAIL blink_period: %0d cycles want %0d", c - last, BD*SCAN_DIV);
                    end
                end
                last = c;
                nchg++;
            end
            prev_nib = disp_bcd[3:0];
        end
        tests_run++;
        if (nchg < 4) begin tests_failed++; $display("FAIL blink_toggles: %0d want >=4", nchg); end
        blink_mask = 4'b1111;
        mode = 2'd1;
        for (int c = 0; c < 40 && !done; c++) begin
            cycle(); e = sb_q.pop_front(); obs = {disp_bcd, digit_en, digit_bcd, banner_active};
            tests_run++;
            if (obs !== e) begin tests_failed++; $display("FAIL blink_banner_sb t=%0t got %h want %h", $time, obs, e); end
            if (banner_active) begin
                seen = 1;
                tests_run++;
                if (disp_bcd !== BAN1) begin tests_failed++; $display("FAIL blink_in_banner: disp=%h want %h", disp_bcd, BAN1); end
            end else if (seen) done = 1;
        end
        tests_run++;
        if (!done) begin tests_failed++; $display("FAIL blink_banner_timeout: seen=%0d ended=0 want ended=1", seen); end
    endtask

    task automatic test_invalid();
        exp_t e, obs;
        settle();
        mode = 2'd3;
        repeat (12) begin
            cycle(); e = sb_q.pop_front(); obs = {disp_bcd, digit_en, digit_bcd, banner_active};
            tests_run++;
            if (obs !== e) begin tests_failed++; $display("FAIL invalid_sb t=%0t got %h want %h", $time, obs, e); end
            tests_run++;
            if (disp_bcd !== 16'hFFFF || banner_active !== 1'b0) begin
                tests_failed++; $display("FAIL invalid_blank: disp=%h ba=%b want FFFF 0", disp_bcd, banner_active);
            end
        end
        mode = 2'd0;
        cycle(); e = sb_q.pop_front(); obs = {disp_bcd, digit_en, digit_bcd, banner_active};
        tests_run++;
        if (obs !== e) begin tests_failed++; $display("FAIL invalid_sb t=%0t got %h want %h", $time, obs, e); end
        tests_run++;
        if (banner_active !== 1'b1 || disp_bcd !== BAN0) begin
            tests_failed++; $display("FAIL invalid_exit: ba=%b disp=%h want 1 %h", banner_active, disp_bcd, BAN0);
        end
    endtask

    task automatic test_reset_mid_banner();
        exp_t e, obs;
        repeat (2) begin
            cycle(); e = sb_q.pop_front(); obs = {disp_bcd, digit_en, digit_bcd, banner_active};
            tests_run++;
            if (obs !== e) begin tests_failed++; $display("FAIL rstmid_sb t=%0t got %h want %h", $time, obs, e); end
        end
        rst = 1'b1; mode = 2'd2;
        cycle(); e = sb_q.pop_front(); obs = {disp_bcd, digit_en, digit_bcd, banner_active};
        tests_run++;
        if (obs !== e) begin tests_failed++; $display("FAIL rstmid_sb t=%0t got %h want %h", $time, obs, e); end
        tests_run++;
        if (disp_bcd !== 16'hFFFF || digit_en !== 4'b0001 || digit_bcd !== 4'hF || banner_active !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_values: disp=%h en=%b bcd=%h ba=%b want FFFF 0001 F 0",
                     disp_bcd, digit_en, digit_bcd, banner_active);
        end
        rst = 1'b0;
        cycle(); e = sb_q.pop_front(); obs = {disp_bcd, digit_en, digit_bcd, banner_active};
        tests_run++;
        if (obs !== e) begin tests_failed++; $display("FAIL rstmid_sb t=%0t got %h want %h", $time, obs, e); end
        tests_run++;
        if (banner_active !== 1'b1 || disp_bcd !== BAN2) begin
            tests_failed++; $display("FAIL rstmid_reenter: ba=%b disp=%h want 1 %h", banner_active, disp_bcd, BAN2);
        end
        settle();
    endtask

    initial begin
        rst        = 1'b1;
        mode       = 2'd0;
        blink_mask = 4'b0000;
        src_bcd    = {SRC2, SRC1, SRC0};
        banner_bcd = {BAN2, BAN1, BAN0};
        test_reset();
        test_scan();
        test_banner();
        test_restart();
        test_load_wins();
        test_blink();
        test_invalid();
        test_reset_mid_banner();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/show_sel_scan.md
SHOW_SEL_SCAN -- requirements
Module: show_sel_scan

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of 7-segment digits driven; legal range 2..8.
REQ-002 Parameter NUM_SRC, default 3: number of selectable display sources/modes; MW = max(1, clog2(NUM_SRC)).
REQ-003 Parameter SCAN_DIV, default 50000: clk cycles per digit-scan tick; minimum 2.
REQ-004 Parameter BANNER_TICKS, default 4000: scan ticks a mode banner is held after a mode change; minimum 1.
REQ-005 Parameter BLINK_DIV, default 250: scan ticks per blink half-period; minimum 1.
REQ-006 clk  in  1  system clock; the only clock.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 mode  in  MW  selected source index.
REQ-009 src_bcd  in  NUM_SRC*NUM_DIGITS*4  per-source digit codes; source s, digit d at bits [(s*NUM_DIGITS+d)*4 +: 4], digit 0 rightmost.
REQ-010 banner_bcd  in  NUM_SRC*NUM_DIGITS*4  per-source label codes, same packing.
REQ-011 blink_mask  in  NUM_DIGITS  digits to blink in SHOW state.
REQ-012 disp_bcd  out  NUM_DIGITS*4  registered frame currently displayed.
REQ-013 digit_en  out  NUM_DIGITS  one-hot active-high digit enable.
REQ-014 digit_bcd  out  4  code for the enabled digit.
REQ-015 banner_active  out  1  high while in BANNER state.

Function
REQ-016 The prescaler SHALL count 0..SCAN_DIV-1 and assert a one-cycle scan tick on the cycle it wraps to 0.
REQ-017 On each scan tick the scan index SHALL advance by one, wrapping NUM_DIGITS-1 -> 0; digit_en and digit_bcd SHALL update on that same edge.
REQ-018 digit_bcd SHALL equal the disp_bcd slice selected by the new scan index (sampled from disp_bcd as registered on the tick edge).
REQ-019 The FSM SHALL have states SHOW and BANNER; mode_q SHALL register mode every cycle.
REQ-020 When mode != mode_q and mode < NUM_SRC: go to BANNER and load banner counter with BANNER_TICKS; applies from either state, so a change during BANNER restarts the count.
REQ-021 In BANNER the counter SHALL decrement per scan tick; on the tick that makes it 0, return to SHOW.
REQ-022 disp_bcd SHALL be registered every cycle (one-cycle latency from inputs): BANNER -> banner_bcd[mode]; SHOW -> src_bcd[mode] with masked digits forced to 4'd15 while blink phase is 1.
REQ-023 Blink phase SHALL toggle every BLINK_DIV scan ticks in both states; blinking SHALL not be applied in BANNER.
REQ-024 mode >= NUM_SRC SHALL force disp_bcd to all 4'd15 and SHALL not trigger BANNER; state SHALL be SHOW.
REQ-025 A mode change and a scan tick in the same cycle SHALL load the counter with BANNER_TICKS (load wins over decrement).

Reset
REQ-026 Under rst: prescaler 0, scan index 0, digit_en = 1 (digit 0), digit_bcd = 4'd15, disp_bcd all 4'd15, state SHOW, banner_active 0, mode_q 0, blink phase 0, banner counter 0.
REQ-027 rst asserted mid-banner or mid-scan SHALL take effect at the next edge; after release, a mode != 0 SHALL trigger BANNER one cycle later.

Structure
REQ-028 State encodings, the blank code 4'd15, and the label codes (L = 12, V = 10) SHALL live in the shared defines header alongside the existing mode defines.
REQ-029 The prescaler SHALL be a sub-module named tick_gen (parameter DIV, outputs a one-cycle tick).

Verification (NUM_DIGITS=4, NUM_SRC=3, SCAN_DIV=4, BANNER_TICKS=2, BLINK_DIV=2)
REQ-030 Reset, mode=0, src0=1234 -> disp_bcd 1234 one cycle after release; digit_en cycles 0001,0010,0100,1000,0001 every 4 clk; digit_bcd 4,3,2,1.
REQ-031 mode 0 -> 2, banner2 = C,A,F,x -> banner_active high for exactly 2 scan ticks showing the banner, then src2 shown.
REQ-032 Mode 0->1, then ->2 after 1 tick -> banner restarts; total banner 3 ticks; label is banner2.
REQ-033 blink_mask=0001, SHOW -> digit 0 alternates value/15 every 2 scan ticks; no blanking during a banner.
REQ-034 mode=3 -> disp_bcd FFFF, banner_active stays 0.
REQ-035 rst pulse during banner -> all outputs at REQ-026 values next edge; banner re-enters if mode != 0.
